// File: rtl/m_mux_onehot_pipe.sv
// m_mux_onehot_pipe: one-hot output-port multiplexer for the router crossbar.
// Selects one of P_NUM_IN channels by a one-hot select. It holds that channel
// from the head flit to the tail flit of a packet. Accepted flits go out
// through a registered 2-entry valid/ready buffer.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   select     one-hot channel select, sampled only in IDLE
//   data_in    flattened channel data, channel i at [i*P_DATA_WIDTH +: P_DATA_WIDTH]
//   in_valid   upstream flit valid
//   in_tail    flit is the last of its packet
//   in_ready   block can accept a flit
//   data_out   head-of-buffer flit
//   out_valid  data_out valid
//   out_ready  downstream accepts
//   busy       packet lock held
//   sel_error  sticky flag: multi-hot select seen in IDLE with in_valid
module m_mux_onehot_pipe #(
    parameter int unsigned P_DATA_WIDTH    = 8,
    parameter int unsigned P_NUM_IN        = 6,
    parameter int unsigned P_ZERO_SEL_LAST = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [P_NUM_IN-1:0]              select,
    input  logic [P_NUM_IN*P_DATA_WIDTH-1:0] data_in,
    input  logic                             in_valid,
    input  logic                             in_tail,
    output logic                             in_ready,
    output logic [P_DATA_WIDTH-1:0]          data_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             sel_error
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam logic [P_NUM_IN-1:0] ZeroSelRoute = {1'b1, {(P_NUM_IN-1){1'b0}}};

    state_e                    state_q, state_d;
    logic [P_NUM_IN-1:0]       lock_sel_q, lock_sel_d;
    logic                      sel_error_q, sel_error_d;
    logic [P_DATA_WIDTH-1:0]   mem_q [2];
    logic [P_DATA_WIDTH-1:0]   mem_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;

    logic                      accept;
    logic                      pop;
    logic                      push;
    logic                      sel_zero;
    logic                      sel_onehot;
    logic [P_NUM_IN-1:0]       eff_sel;
    logic                      eff_valid;
    logic [P_DATA_WIDTH-1:0]   mux_data;

    assign in_ready  = (count_q != 2'd2) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign data_out  = mem_q[rd_ptr_q];
    assign busy      = (state_q == StLocked);
    assign sel_error = sel_error_q;

    assign accept     = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign sel_zero   = (select == '0);
    assign sel_onehot = ($countones(select) == 1);

    // Effective select: lock in LOCKED; in IDLE a zero select either maps to the
    // last channel (idle-port convention) or is dropped.
    always_comb begin
        eff_sel   = select;
        eff_valid = sel_onehot;
        if (state_q == StLocked) begin
            eff_sel   = lock_sel_q;
            eff_valid = 1'b1;
        end else if (sel_zero && (P_ZERO_SEL_LAST != 0)) begin
            eff_sel   = ZeroSelRoute;
            eff_valid = 1'b1;
        end
    end

    // AND-OR mux; eff_sel is one-hot whenever the result is used.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < int'(P_NUM_IN); i++) begin
            if (eff_sel[i]) begin
                mux_data = mux_data | data_in[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    assign push = accept && eff_valid;

    // Packet lock FSM and sticky error.
    always_comb begin
        state_d     = state_q;
        lock_sel_d  = lock_sel_q;
        sel_error_d = sel_error_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (eff_valid) begin
                        if (!in_tail) begin
                            lock_sel_d = eff_sel;
                            state_d    = StLocked;
                        end
                    end else if (!sel_zero) begin
                        // Multi-hot: flit dropped, later flits treated as new heads.
                        sel_error_d = 1'b1;
                    end
                end
            end
            StLocked: begin
                if (accept && in_tail) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output buffer next state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = mux_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lock_sel_q  <= '0;
            sel_error_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            lock_sel_q  <= lock_sel_d;
            sel_error_q <= sel_error_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/m_mux_onehot_pipe.md
# m_mux_onehot_pipe

Parametrised one-hot output-port multiplexer with packet lock and a registered 2-entry output buffer. It is the next-generation switch stage of the router crossbar. It selects one of P_NUM_IN input channels with a one-hot select and holds that selection from the head flit to the tail flit of a packet. Accepted flits are delivered downstream through a valid/ready output buffer. Malformed selects are detected and reported.

## Interface
Parameters:
- P_DATA_WIDTH, 8, flit width in bits
- P_NUM_IN, 6, number of input channels (≥2)
- P_ZERO_SEL_LAST, 1, 1: select==0 routes channel P_NUM_IN-1 (idle-port convention); 0: select==0 drops the flit

Ports (the clock is `clk`; reset is `rst`, synchronous and active-high; there is one clock domain):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- select  in  P_NUM_IN  one-hot channel select, sampled only in IDLE
- data_in  in  P_NUM_IN*P_DATA_WIDTH  flattened channel data; channel i at bits [i*P_DATA_WIDTH +: P_DATA_WIDTH]
- in_valid  in  1  upstream flit valid
- in_tail  in  1  accompanying flit is last of packet (single-flit packet: head and tail together)
- in_ready  out  1  block can accept a flit
- data_out  out  P_DATA_WIDTH  head-of-buffer flit
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts
- busy  out  1  packet lock held (state LOCKED)
- sel_error  out  1  sticky: non-one-hot, non-zero select seen in IDLE with in_valid

## Operation
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- The state machine has two states, IDLE and LOCKED.
- IDLE, accept, select one-hot:
  - Mux the selected channel and push it into the buffer.
  - If in_tail=0, capture select into lock_sel and go to LOCKED.
  - Otherwise stay in IDLE.
- IDLE, accept, select==0:
  - P_ZERO_SEL_LAST=1: behave as if select had only bit P_NUM_IN-1 set (lock rules as above).
  - P_ZERO_SEL_LAST=0: consume the flit without pushing it; state unchanged; no error.
- IDLE, accept, popcount(select)>1: consume the flit without pushing it, set sel_error, stay in IDLE. The remaining flits of that packet are each treated as new heads.
- LOCKED, accept:
  - Mux by lock_sel and ignore select.
  - Push the flit.
  - On in_tail=1, return to IDLE.
- busy = (state==LOCKED).
- Buffer: 2-entry FIFO with count 0..2.
  - Push and pop in the same cycle leaves count unchanged; data order is preserved.
  - in_ready = (count<2) && !rst.
  - out_valid = (count!=0).
- sel_error clears only on rst.
- Reset values: count=0, out_valid=0, data_out=0, busy=0, sel_error=0, state=IDLE, lock_sel=0. in_ready=0 during reset and 1 in the first cycle after reset.
- Reset mid-packet: buffer contents and lock are discarded. The next accepted flit is treated as a head.

## Timing
- Latency: a flit accepted at edge k appears on data_out with out_valid=1 after edge k; it is visible in cycle k+1.
- Throughput: 1 flit/cycle while out_ready=1.
- Full (count=2): in_ready=0. No push that cycle, even if out_ready=1; in_ready rises after the pop edge.
- Empty (count=0) with push: out_valid rises the next cycle. There is no combinational bypass from data_in to data_out.
- Lock capture and lock release (tail) happen on the same edge as the accept.
- select changing while LOCKED has no effect and raises no error.
- data_out is held stable while out_valid=1 && out_ready=0.
- Non-accepted cycles (in_valid=0 or in_ready=0) change no state except by pop.

## Test plan
- Reset, then IDLE flits with select=6'b000100, tail=1, data_in ch2=8'hA5, out_ready=1 → data_out=8'hA5, out_valid=1 one cycle after accept; busy stays 0.
- 3-flit packet (select=6'b000010, then 6'b010000 on flits 2–3, tail on flit 3) carrying 8'h11/22/33 on ch1 → all three flits output from ch1 in order; busy=1 after flit 1 until after flit 3.
- out_ready=0 with 3 valid flits offered → 2 accepted, then in_ready=0. Raise out_ready → outputs in order, no loss or duplication; data_out stable while stalled.
- select=6'b000011 with in_valid → nothing output, sel_error=1 and stays 1 until rst. Next one-hot flit is routed normally.
- select=0: with P_ZERO_SEL_LAST=1, ch5=8'h5C is output; with P_ZERO_SEL_LAST=0, no output and sel_error stays 0.
- rst asserted mid-packet with count=2 → next cycle out_valid=0, busy=0, data_out=0. After reset, a flit with a new select is routed per that select.
